// File: rtl/ifetch_queue.sv
// Instruction-fetch byte queue: fetches opcode bytes into a DEPTH-entry ring and
// presents the oldest four as a window. Define IFETCH_QUEUE_DEBUG_EN to expose occupancy/state.
module ifetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush0,
    input  logic [15:0] targetPC,
    output logic [15:0] I_addr,
    output logic        I_rd,
    input  logic [7:0]  I_data,
    input  logic        I_wait,
    output logic [31:0] win_data,
    output logic [2:0]  win_count,
    output logic [15:0] win_pc,
    input  logic [2:0]  consume
`ifdef IFETCH_QUEUE_DEBUG_EN
    ,
    output logic [3:0]  DEBUG_occ,
    output logic [1:0]  DEBUG_state
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        FULL     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   win_pc_q, win_pc_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [2:0]    win_count_q, win_count_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic          capture;
    logic [2:0]    cons_eff;
    logic [PW-1:0] rd_idx;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        win_pc_d    = win_pc_q;
        occ_d       = occ_q;
        head_d      = head_q;
        tail_d      = tail_q;
        win_count_d = win_count_q;
        mem_d       = mem_q;

        // The request is masked while reset is held so memory sees no fetch in that cycle.
        I_rd     = (state_q == FETCH) && !RST;
        capture  = I_rd && !I_wait;
        cons_eff = (consume > win_count_q) ? win_count_q : consume;

        if (flush0) begin
            state_d     = REDIRECT;
            fetch_pc_d  = targetPC;
            win_pc_d    = targetPC;
            occ_d       = '0;
            head_d      = '0;
            tail_d      = '0;
            win_count_d = '0;
        end else begin
            if (capture) begin
                mem_d[tail_q] = I_data;
                tail_d        = tail_q + PW'(1);
                fetch_pc_d    = fetch_pc_q + 16'd1;
            end
            head_d      = head_q + PW'(cons_eff);
            win_pc_d    = win_pc_q + 16'(cons_eff);
            occ_d       = occ_q + OW'(capture) - OW'(cons_eff);
            win_count_d = (occ_d > OW'(4)) ? 3'd4 : 3'(occ_d);
            case (state_q)
                FETCH:    if (occ_d == OW'(DEPTH)) state_d = FULL;
                FULL:     if (occ_d < OW'(DEPTH))  state_d = FETCH;
                REDIRECT: state_d = FETCH;
                default:  state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FETCH;
            fetch_pc_q  <= '0;
            win_pc_q    <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            win_count_q <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            win_pc_q    <= win_pc_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            win_count_q <= win_count_d;
            mem_q       <= mem_d;
        end
    end

    // Window bytes beyond the valid count read as zero.
    always_comb begin
        win_data = '0;
        rd_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            rd_idx = head_q + PW'(i);
            if (3'(i) < win_count_q) win_data[8*i +: 8] = mem_q[rd_idx];
        end
    end

    assign I_addr    = fetch_pc_q;
    assign win_count = win_count_q;
    assign win_pc    = win_pc_q;

`ifdef IFETCH_QUEUE_DEBUG_EN
    assign DEBUG_occ   = 4'(occ_q);
    assign DEBUG_state = state_q;
`endif

endmodule
